uart_mem_bridge: RTL and testbench

//  Parametrised UART-to-memory command engine; sits between uart_rx/uart_tx and BRAM/SPRAM muxes.

---
 rtl/uart_bridge_pkg.sv | 28 ++
 rtl/uart_bridge_txseq.sv | 46 ++++
 rtl/uart_mem_bridge.sv | 218 +++++++++++++++++++++
 tb/tb_uart_mem_bridge.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART-to-memory command bridge.
package uart_bridge_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_BOOT,
    S_ADDR,
    S_LEN,
    S_RD_REQ,
    S_RD_WAIT,
    S_TX_BYTE,
    S_TX_WAIT,
    S_TX_CSUM,
    S_RX_DATA,
    S_WR,
    S_RX_CSUM,
    S_TX_STATUS
  } state_t;

  localparam int CMD_REGION = 7;
  localparam int CMD_WRITE  = 6;
  localparam int CMD_BOOT   = 5;

  localparam logic [7:0] ST_OK      = 8'hA5;
  localparam logic [7:0] ST_BAD     = 8'hE1;
  localparam logic [7:0] ST_TIMEOUT = 8'hE2;

endpackage

// File: rtl/uart_bridge_txseq.sv
// Single-byte transmit sequencer: waits for an idle transmitter, pulses tx_en,
// then tracks busy rise and fall before reporting done.
module uart_bridge_txseq (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       tx_busy,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       done
);

  typedef enum logic [1:0] {T_IDLE, T_PEND, T_RISE, T_FALL} tstate_t;

  tstate_t st;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st      <= T_IDLE;
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
      done    <= 1'b0;
    end else begin
      tx_en <= 1'b0;
      done  <= 1'b0;
      case (st)
        T_IDLE: if (start) begin
          tx_data <= byte_in;
          st      <= T_PEND;
        end
        T_PEND: if (!tx_busy) begin
          tx_en <= 1'b1;
          st    <= T_RISE;
        end
        T_RISE: if (tx_busy) st <= T_FALL;
        T_FALL: if (!tx_busy) begin
          done <= 1'b1;
          st   <= T_IDLE;
        end
        default: st <= T_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_mem_bridge.sv
// UART command engine: decodes CMD/address/length from the host and runs
// checksummed word bursts against BRAM/SPRAM, plus warmboot requests.
module uart_mem_bridge
  import uart_bridge_pkg::*;
#(
  parameter int DATA_BYTES  = 2,
  parameter int ADDR_BYTES  = 2,
  parameter int LEN_BYTES   = 1,
  parameter int SEL_BITS    = 4,
  parameter int RD_LATENCY  = 1,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  input  logic                      tx_busy,
  output logic                      tx_en,
  output logic [7:0]                tx_data,
  output logic [SEL_BITS-1:0]       mem_sel,
  output logic                      mem_region,
  output logic [8*ADDR_BYTES-1:0]   mem_addr,
  output logic                      mem_re,
  output logic                      mem_we,
  output logic [8*DATA_BYTES-1:0]   mem_wdata,
  input  logic [8*DATA_BYTES-1:0]   mem_rdata,
  output logic                      warmboot,
  output logic [1:0]                warmboot_sel,
  output logic                      active,
  output logic                      err_timeout
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int AW = 8 * ADDR_BYTES;
  localparam int LW = 8 * LEN_BYTES;
  localparam int OW = LW + 1;

  state_t                state;
  logic                  cmd_write;
  logic [AW-1:0]         base;
  logic [LW-1:0]         len;
  logic [OW-1:0]         offset;
  logic [7:0]            csum;
  logic [DW-1:0]         word;
  logic [7:0]            byte_cnt;
  logic [1:0]            lat_cnt;
  logic [31:0]           to_cnt;
  logic                  rx_prev;
  logic                  tx_start;
  logic [7:0]            tx_byte;
  logic                  tx_done;
  logic                  rx_stb;
  logic                  timed;
  logic                  timeout;

  // rx_prev resets high so a level already present at reset release is not a new byte
  assign rx_stb  = rx_valid & ~rx_prev;
  assign timed   = (state == S_ADDR) || (state == S_LEN) ||
                   (state == S_RX_DATA) || (state == S_RX_CSUM);
  assign timeout = (TIMEOUT_CYC != 0) && timed && !rx_stb &&
                   (to_cnt == 32'(TIMEOUT_CYC - 1));

  assign mem_addr = base + AW'(offset);
  assign active   = (state != S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      cmd_write    <= 1'b0;
      mem_sel      <= '0;
      mem_region   <= 1'b0;
      base         <= '0;
      len          <= '0;
      offset       <= '0;
      csum         <= 8'h00;
      word         <= '0;
      byte_cnt     <= 8'h00;
      lat_cnt      <= 2'd0;
      to_cnt       <= 32'd0;
      rx_prev      <= 1'b1;
      tx_start     <= 1'b0;
      tx_byte      <= 8'h00;
      mem_re       <= 1'b0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      warmboot     <= 1'b0;
      warmboot_sel <= 2'd0;
      err_timeout  <= 1'b0;
    end else begin
      rx_prev     <= rx_valid;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      err_timeout <= 1'b0;
      tx_start    <= 1'b0;
      to_cnt      <= (timed && !rx_stb) ? to_cnt + 32'd1 : 32'd0;

      if (timeout) begin
        err_timeout <= 1'b1;
        tx_byte     <= ST_TIMEOUT;
        tx_start    <= 1'b1;
        state       <= S_TX_STATUS;
      end else begin
        case (state)
          S_IDLE: if (rx_stb) begin
            cmd_write  <= rx_data[CMD_WRITE];
            mem_region <= rx_data[CMD_REGION];
            mem_sel    <= rx_data[SEL_BITS-1:0];
            byte_cnt   <= 8'h00;
            if (rx_data[CMD_BOOT]) begin
              warmboot     <= 1'b1;
              warmboot_sel <= rx_data[1:0];
              state        <= S_BOOT;
            end else begin
              state <= S_ADDR;
            end
          end
          S_BOOT: state <= S_BOOT;
          S_ADDR: if (rx_stb) begin
            base <= (base << 8) | AW'(rx_data);
            if (byte_cnt == 8'(ADDR_BYTES - 1)) begin
              byte_cnt <= 8'h00;
              state    <= S_LEN;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
          S_LEN: if (rx_stb) begin
            len <= (len << 8) | LW'(rx_data);
            if (byte_cnt == 8'(LEN_BYTES - 1)) begin
              byte_cnt <= 8'h00;
              offset   <= '0;
              csum     <= 8'h00;
              state    <= cmd_write ? S_RX_DATA : S_RD_REQ;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
          S_RD_REQ: begin
            mem_re  <= 1'b1;
            lat_cnt <= 2'd0;
            state   <= S_RD_WAIT;
          end
          S_RD_WAIT: begin
            if (lat_cnt == 2'(RD_LATENCY)) begin
              word     <= mem_rdata;
              byte_cnt <= 8'h00;
              state    <= S_TX_BYTE;
            end else begin
              lat_cnt <= lat_cnt + 2'd1;
            end
          end
          S_TX_BYTE: begin
            tx_byte  <= word[DW-1 -: 8];
            csum     <= csum ^ word[DW-1 -: 8];
            tx_start <= 1'b1;
            state    <= S_TX_WAIT;
          end
          S_TX_WAIT: if (tx_done) begin
            word <= word << 8;
            if (byte_cnt == 8'(DATA_BYTES - 1)) begin
              byte_cnt <= 8'h00;
              if (offset == OW'(len)) begin
                tx_byte  <= csum;
                tx_start <= 1'b1;
                state    <= S_TX_CSUM;
              end else begin
                offset <= offset + OW'(1);
                state  <= S_RD_REQ;
              end
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
              state    <= S_TX_BYTE;
            end
          end
          S_TX_CSUM, S_TX_STATUS: if (tx_done) state <= S_IDLE;
          S_RX_DATA: if (rx_stb) begin
            word <= (word << 8) | DW'(rx_data);
            csum <= csum ^ rx_data;
            if (byte_cnt == 8'(DATA_BYTES - 1)) begin
              byte_cnt  <= 8'h00;
              mem_we    <= 1'b1;
              mem_wdata <= (word << 8) | DW'(rx_data);
              state     <= S_WR;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
          S_WR: begin
            if (offset == OW'(len)) begin
              state <= S_RX_CSUM;
            end else begin
              offset <= offset + OW'(1);
              state  <= S_RX_DATA;
            end
          end
          S_RX_CSUM: if (rx_stb) begin
            tx_byte  <= (rx_data == csum) ? ST_OK : ST_BAD;
            tx_start <= 1'b1;
            state    <= S_TX_STATUS;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  uart_bridge_txseq u_txseq (
    .clk     (clk),
    .resetn  (resetn),
    .start   (tx_start),
    .byte_in (tx_byte),
    .tx_busy (tx_busy),
    .tx_en   (tx_en),
    .tx_data (tx_data),
    .done    (tx_done)
  );

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge with a busy-driven transmitter model and a
// latency-1 memory model.
module tb_uart_mem_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_busy;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic [3:0]  mem_sel;
  logic        mem_region;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        warmboot;
  logic [1:0]  warmboot_sel;
  logic        active;
  logic        err_timeout;

  int n_checks = 0;
  int n_err = 0;

  logic [15:0] mem [0:65535];
  logic [7:0]  tx_q[$];
  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [3:0]  wr_sel_q[$];
  int          busy_cnt;

  always #5 clk = ~clk;

  uart_mem_bridge #(
    .DATA_BYTES (2),
    .ADDR_BYTES (2),
    .LEN_BYTES  (1),
    .SEL_BITS   (4),
    .RD_LATENCY (1),
    .TIMEOUT_CYC(50)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_busy     (tx_busy),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .mem_sel     (mem_sel),
    .mem_region  (mem_region),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .warmboot    (warmboot),
    .warmboot_sel(warmboot_sel),
    .active      (active),
    .err_timeout (err_timeout)
  );

  // Transmitter: goes busy the cycle after tx_en and stays busy for four cycles
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (tx_en) begin
      tx_busy  <= 1'b1;
      busy_cnt <= 3;
      tx_q.push_back(tx_data);
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      tx_busy <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      wr_sel_q.push_back(mem_sel);
    end
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(2);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c = 0;
    while (active && c < budget) begin
      tick(1);
      c++;
    end
    check(tag, 32'(active), 32'd0);
  endtask

  initial begin
    int tb0;
    int wb0;
    int c;
    logic [7:0] exp_csum;

    mem[16] = 16'h1234;
    mem[17] = 16'hABCD;
    mem_rdata = 16'h0000;

    // Reset with rx_valid already high: the held level must not count as a byte
    rx_valid = 1'b1;
    rx_data  = 8'h22;
    tick(3);
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_warmboot", 32'(warmboot), 32'd0);
    resetn = 1'b1;
    tick(5);
    check("held_rx_active", 32'(active), 32'd0);
    check("held_rx_warmboot", 32'(warmboot), 32'd0);
    rx_valid = 1'b0;
    tick(2);

    // Test 1: read burst of two words from 0x0010
    tb0 = tx_q.size();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h01);
    wait_idle("rd_idle", 500);
    exp_csum = 8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD;
    check("rd_count", 32'(tx_q.size() - tb0), 32'd5);
    check("rd_b0", 32'(tx_q[tb0]), 32'h12);
    check("rd_b1", 32'(tx_q[tb0+1]), 32'h34);
    check("rd_b2", 32'(tx_q[tb0+2]), 32'hAB);
    check("rd_b3", 32'(tx_q[tb0+3]), 32'hCD);
    check("rd_csum", 32'(tx_q[tb0+4]), 32'(exp_csum));
    check("rd_no_write", 32'(wr_addr_q.size()), 32'd0);

    // Test 2: single-word write with good checksum
    tb0 = tx_q.size();
    wb0 = wr_addr_q.size();
    send_byte(8'h45);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h51);
    wait_idle("wr_idle", 500);
    check("wr_count", 32'(wr_addr_q.size() - wb0), 32'd1);
    check("wr_addr", 32'(wr_addr_q[wb0]), 32'h00FF);
    check("wr_data", 32'(wr_data_q[wb0]), 32'hBEEF);
    check("wr_sel", 32'(wr_sel_q[wb0]), 32'd5);
    check("wr_region", 32'(mem_region), 32'd0);
    check("wr_status", 32'(tx_q[tb0]), 32'hA5);

    // Test 3: same write with a bad checksum still writes, reports 0xE1
    tb0 = tx_q.size();
    wb0 = wr_addr_q.size();
    send_byte(8'h45);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h00);
    wait_idle("bad_idle", 500);
    check("bad_wcount", 32'(wr_addr_q.size() - wb0), 32'd1);
    check("bad_wdata", 32'(wr_data_q[wb0]), 32'hBEEF);
    check("bad_status", 32'(tx_q[tb0]), 32'hE1);

    // Test 4: two-word write starting at 0xFFFF wraps to 0x0000
    tb0 = tx_q.size();
    wb0 = wr_addr_q.size();
    send_byte(8'h40);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
    wait_idle("wrap_idle", 500);
    check("wrap_count", 32'(wr_addr_q.size() - wb0), 32'd2);
    check("wrap_addr0", 32'(wr_addr_q[wb0]), 32'hFFFF);
    check("wrap_data0", 32'(wr_data_q[wb0]), 32'h1122);
    check("wrap_addr1", 32'(wr_addr_q[wb0+1]), 32'h0000);
    check("wrap_data1", 32'(wr_data_q[wb0+1]), 32'h3344);
    check("wrap_status", 32'(tx_q[tb0]), 32'hA5);

    // Test 5: command and address only, then silence until timeout
    tb0 = tx_q.size();
    wb0 = wr_addr_q.size();
    send_byte(8'h40);
    send_byte(8'h00);
    send_byte(8'h00);
    c = 0;
    while (!err_timeout && c < 100) begin
      tick(1);
      c++;
    end
    check("to_pulse", 32'(err_timeout), 32'd1);
    check("to_latency", 32'(c), 32'd48);
    tick(1);
    check("to_one_cycle", 32'(err_timeout), 32'd0);
    wait_idle("to_idle", 500);
    check("to_status", 32'(tx_q[tb0]), 32'hE2);
    check("to_no_write", 32'(wr_addr_q.size() - wb0), 32'd0);
    check("to_active", 32'(active), 32'd0);

    // Test 6: warmboot held until reset, then reset in the middle of a read burst
    send_byte(8'h22);
    tick(20);
    check("boot_flag", 32'(warmboot), 32'd1);
    check("boot_sel", 32'(warmboot_sel), 32'd2);
    check("boot_active", 32'(active), 32'd1);
    resetn = 1'b0;
    #1;
    check("boot_rst_flag", 32'(warmboot), 32'd0);
    check("boot_rst_sel", 32'(warmboot_sel), 32'd0);
    tick(2);
    resetn = 1'b1;
    tick(2);

    send_byte(8'h83);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h01);
    c = 0;
    while (!tx_en && c < 100) begin
      tick(1);
      c++;
    end
    check("mid_tx_started", 32'(tx_en), 32'd1);
    check("mid_region", 32'(mem_region), 32'd1);
    tick(3);
    resetn = 1'b0;
    #1;
    check("mid_tx_en", 32'(tx_en), 32'd0);
    check("mid_tx_data", 32'(tx_data), 32'd0);
    check("mid_active", 32'(active), 32'd0);
    check("mid_mem_addr", 32'(mem_addr), 32'd0);
    check("mid_mem_sel", 32'(mem_sel), 32'd0);
    check("mid_region_rst", 32'(mem_region), 32'd0);
    check("mid_mem_re", 32'(mem_re), 32'd0);
    check("mid_mem_wdata", 32'(mem_wdata), 32'd0);
    check("mid_err", 32'(err_timeout), 32'd0);
    tick(2);
    resetn = 1'b1;
    tb0 = tx_q.size();
    tick(30);
    check("post_rst_no_tx", 32'(tx_q.size() - tb0), 32'd0);
    check("post_rst_active", 32'(active), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
